pad_bidir_bank: RTL and testbench

Parametrised bank of `WIDTH` bidirectional pad channels for the I2C/control interfaces of the synthesizer core. Each channel does three jobs:
- Registers the core's drive request into per-channel pad-cell controls `pad_do` and `pad_oe`, using push-pull or open-drain signalling selected per channel.
- Synchronises and glitch-filters the pad readback.
- Reports edges and drive/readback mismatches.

The block sits between protocol engines (I2C master, GPIO) and the pad cells with their output buffer chains.

---
 rtl/pad_bidir_bank.sv | 176 +++++++++++++++++
 tb/tb_pad_bidir_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_bidir_bank.sv
// ---------------------------------------------------------------------------
// pad_bidir_bank
//
// Bank of WIDTH independent bidirectional pad channels sitting between the
// protocol engines (I2C master, GPIO) and the pad cells.  Per channel:
//   - registers the core drive request into pad-cell controls, using
//     push-pull or open-drain signalling (OD_MASK bit = 1 -> open-drain),
//   - synchronises and glitch-filters the asynchronous pad readback,
//   - reports filtered edges and sticky drive/readback mismatches.
//
// Parameters:
//   WIDTH       number of channels
//   SYNC_STAGES synchroniser depth (2..4)
//   FILT_CYCLES consecutive stable samples needed to accept a level (0 = off)
//   OD_MASK     per-channel open-drain select
//   ERR_WIN     consecutive mismatch cycles that set err (>= 1)
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   out_data  level the core wants on each pad
//   out_en    core drive request per channel
//   pad_in    raw asynchronous readback from the pad cells
//   pad_do    data to pad cell (registered)
//   pad_oe    output enable to pad cell (registered)
//   in_data   synchronised, filtered pad level
//   in_rise   one-cycle pulse on filtered 0->1
//   in_fall   one-cycle pulse on filtered 1->0
//   err_clr   clears the matching sticky error bit
//   err       sticky drive/readback mismatch flag
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module pad_bidir_bank #(
  parameter int               WIDTH       = 2,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] OD_MASK     = {WIDTH{1'b1}},
  parameter int               ERR_WIN     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] out_data,
  input  logic [WIDTH-1:0] out_en,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_do,
  output logic [WIDTH-1:0] pad_oe,
  output logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] in_rise,
  output logic [WIDTH-1:0] in_fall,
  input  logic [WIDTH-1:0] err_clr,
  output logic [WIDTH-1:0] err
);

  // Counter widths; a zero-width counter is never legal, so floor at 1 bit.
  localparam int CNT_W = (FILT_CYCLES > 0) ? $clog2(FILT_CYCLES + 1) : 1;
  localparam int ERR_W = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FILT_CYCLES > 0) ? FILT_CYCLES - 1 : 0);
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_WIN - 1);

  // Filter counter advance: wraps to zero once the new level is accepted.
  function automatic logic [CNT_W-1:0] filt_next(input logic [CNT_W-1:0] c);
    if (c == CNT_LAST) filt_next = '0;
    else               filt_next = c + 1'b1;
  endfunction

  // Mismatch counter advance: saturates at the terminal value so a
  // persistent mismatch keeps re-asserting the set condition every cycle.
  function automatic logic [ERR_W-1:0] mis_sat_inc(input logic [ERR_W-1:0] c);
    if (c == ERR_LAST) mis_sat_inc = c;
    else               mis_sat_inc = c + 1'b1;
  endfunction

  // -------------------------------------------------------------------------
  // Output stage: core request -> pad-cell controls (1-cycle latency).
  // Open-drain channels never drive high; a requested 1 releases the pad.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_do <= '0;
      pad_oe <= '0;
    end else begin
      pad_do <= out_data & ~OD_MASK;
      pad_oe <= out_en & (~OD_MASK | ~out_data);
    end
  end

  // -------------------------------------------------------------------------
  // Input stage p0: synchroniser chain.  Resets to 1 to match an idle-high
  // bus, so leaving reset never produces a spurious falling edge.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0]                  s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pad_in};
    end
  end

  assign s = sync_p0[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Input stage p1: glitch filter and edge pulses.  A new level is accepted
  // only after FILT_CYCLES consecutive samples differ from in_data; any
  // sample agreeing with in_data restarts the count.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] filt_cnt_p1 [WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_data <= '1;
      in_rise <= '0;
      in_fall <= '0;
      for (int i = 0; i < WIDTH; i++) filt_cnt_p1[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        in_rise[i] <= 1'b0;
        in_fall[i] <= 1'b0;
        if (FILT_CYCLES == 0) begin
          in_data[i]     <= s[i];
          in_rise[i]     <= s[i] & ~in_data[i];
          in_fall[i]     <= ~s[i] & in_data[i];
          filt_cnt_p1[i] <= '0;
        end else if (s[i] == in_data[i]) begin
          filt_cnt_p1[i] <= '0;
        end else begin
          if (filt_cnt_p1[i] == CNT_LAST) begin
            in_data[i] <= s[i];
            in_rise[i] <= s[i];
            in_fall[i] <= ~s[i];
          end
          filt_cnt_p1[i] <= filt_next(filt_cnt_p1[i]);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Check stage p2: drive/readback mismatch.  Only cycles where the pad is
  // actually driven count; for open-drain that means driving low, so a
  // released line pulled low by another master is never flagged.
  // -------------------------------------------------------------------------
  logic [ERR_W-1:0] mis_cnt_p2 [WIDTH];
  logic [WIDTH-1:0] mis;
  logic [WIDTH-1:0] err_set;

  always_comb begin
    mis     = '0;
    err_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mis[i]     = pad_oe[i] & (in_data[i] ^ pad_do[i]);
      err_set[i] = mis[i] & (mis_cnt_p2[i] == ERR_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= '0;
      for (int i = 0; i < WIDTH; i++) mis_cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!mis[i]) mis_cnt_p2[i] <= '0;
        else         mis_cnt_p2[i] <= mis_sat_inc(mis_cnt_p2[i]);

        // Set has priority over a coincident clear.
        if (err_set[i])      err[i] <= 1'b1;
        else if (err_clr[i]) err[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pad_bidir_bank.sv
// ---------------------------------------------------------------------------
// tb_pad_bidir_bank
//
// Directed bench for pad_bidir_bank with channel 0 open-drain and channel 1
// push-pull.  A table of output-path vectors is applied first, followed by
// hand-written sequences for reset, filter latency/glitch and error flags.
// ---------------------------------------------------------------------------
module tb_pad_bidir_bank;

  logic       clk;
  logic       rst_n;
  logic [1:0] out_data;
  logic [1:0] out_en;
  logic [1:0] pad_in;
  logic [1:0] pad_do;
  logic [1:0] pad_oe;
  logic [1:0] in_data;
  logic [1:0] in_rise;
  logic [1:0] in_fall;
  logic [1:0] err_clr;
  logic [1:0] err;

  int total;
  int passed;

  pad_bidir_bank #(
    .WIDTH      (2),
    .SYNC_STAGES(2),
    .FILT_CYCLES(4),
    .OD_MASK    (2'b01),
    .ERR_WIN    (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .out_data(out_data),
    .out_en  (out_en),
    .pad_in  (pad_in),
    .pad_do  (pad_do),
    .pad_oe  (pad_oe),
    .in_data (in_data),
    .in_rise (in_rise),
    .in_fall (in_fall),
    .err_clr (err_clr),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] od;
    logic [1:0] oe;
    logic [1:0] exp_do;
    logic [1:0] exp_oe;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int chg;
    int falls;
    int rises;
    int bad;

    total    = 0;
    passed   = 0;
    rst_n    = 1'b0;
    out_data = 2'b00;
    out_en   = 2'b00;
    pad_in   = 2'b11;
    err_clr  = 2'b00;

    // ch0 open-drain: do always 0, oe = en & ~data; ch1 push-pull.
    vecs[0] = '{od: 2'b00, oe: 2'b00, exp_do: 2'b00, exp_oe: 2'b00};
    vecs[1] = '{od: 2'b11, oe: 2'b11, exp_do: 2'b10, exp_oe: 2'b10};
    vecs[2] = '{od: 2'b00, oe: 2'b11, exp_do: 2'b00, exp_oe: 2'b11};
    vecs[3] = '{od: 2'b01, oe: 2'b11, exp_do: 2'b00, exp_oe: 2'b10};
    vecs[4] = '{od: 2'b10, oe: 2'b01, exp_do: 2'b10, exp_oe: 2'b01};
    vecs[5] = '{od: 2'b10, oe: 2'b10, exp_do: 2'b10, exp_oe: 2'b10};
    vecs[6] = '{od: 2'b01, oe: 2'b01, exp_do: 2'b00, exp_oe: 2'b00};

    // Reset state
    tick();
    tick();
    check("rst_pad_oe", pad_oe, 2'b00);
    check("rst_pad_do", pad_do, 2'b00);
    check("rst_in_data", in_data, 2'b11);
    check("rst_pulses", {in_rise, in_fall}, 4'b0000);
    check("rst_err", err, 2'b00);
    rst_n = 1'b1;
    tick();
    tick();

    // Output path table
    for (int i = 0; i < 7; i++) begin
      out_data = vecs[i].od;
      out_en   = vecs[i].oe;
      tick();
      check($sformatf("vec%0d_pad_do", i), pad_do, vecs[i].exp_do);
      check($sformatf("vec%0d_pad_oe", i), pad_oe, vecs[i].exp_oe);
    end

    // Asynchronous reset mid-drive on push-pull ch1
    out_en   = 2'b10;
    out_data = 2'b10;
    tick();
    check("pre_rst_pad_oe", pad_oe, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pad_oe", pad_oe, 2'b00);
    check("async_rst_pad_do", pad_do, 2'b00);
    out_en   = 2'b00;
    out_data = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_data", in_data, 2'b11);
    check("post_rst_err", err, 2'b00);
    check("post_rst_pulses", {in_rise, in_fall}, 4'b0000);
    out_en   = 2'b10;
    out_data = 2'b10;
    tick();
    check("post_rst_first_drive", pad_oe, 2'b10);
    out_en   = 2'b00;
    out_data = 2'b00;
    tick();

    // Filter latency: falling level on ch0
    pad_in[0] = 1'b0;
    chg = 0; falls = 0; rises = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (in_fall[0]) falls++;
      if (in_rise[0]) rises++;
      if (chg == 0 && in_data[0] == 1'b0) begin
        chg = e;
        check("fall_pulse_with_data", in_fall[0], 1'b1);
      end
    end
    check("fall_latency", chg, 6);
    check("fall_pulse_count", falls, 1);
    check("fall_no_rise", rises, 0);
    check("fall_ch1_idle", in_data[1], 1'b1);

    // Rising level back on ch0
    pad_in[0] = 1'b1;
    chg = 0; rises = 0; falls = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (in_rise[0]) rises++;
      if (in_fall[0]) falls++;
      if (chg == 0 && in_data[0] == 1'b1) chg = e;
    end
    check("rise_latency", chg, 6);
    check("rise_pulse_count", rises, 1);
    check("rise_no_fall", falls, 0);

    // 3-cycle glitch must be swallowed
    pad_in[0] = 1'b0;
    tick(); tick(); tick();
    pad_in[0] = 1'b1;
    bad = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (in_data[0] != 1'b1 || in_rise[0] || in_fall[0]) bad++;
    end
    check("glitch_filtered", bad, 0);

    // Open-drain ch0 released while line held low externally: no error
    out_en    = 2'b01;
    out_data  = 2'b01;
    pad_in[0] = 1'b0;
    for (int e = 0; e < 20; e++) tick();
    check("od_released_oe", pad_oe[0], 1'b0);
    check("od_released_in", in_data[0], 1'b0);
    check("od_released_err", err, 2'b00);
    out_data = 2'b00;
    for (int e = 0; e < 12; e++) tick();
    check("od_low_match_oe", pad_oe[0], 1'b1);
    check("od_low_match_err", err, 2'b00);
    out_en    = 2'b00;
    pad_in[0] = 1'b1;
    for (int e = 0; e < 8; e++) tick();
    check("od_settle_in", in_data, 2'b11);

    // Open-drain ch0 driving low against a stuck-high pad
    out_en   = 2'b01;
    out_data = 2'b00;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == 8) check("od_stuck_err_before", err[0], 1'b0);
      if (e == 9) check("od_stuck_err_set", err, 2'b01);
    end
    out_en = 2'b00;
    tick();
    err_clr = 2'b01;
    tick();
    err_clr = 2'b00;
    check("od_err_cleared", err, 2'b00);

    // Push-pull ch1 driving 1 with pad forced low
    out_en    = 2'b10;
    out_data  = 2'b10;
    pad_in[1] = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 13) check("pp_err_before", err[1], 1'b0);
      if (e == 14) check("pp_err_set", err, 2'b10);
    end
    // Coincident set and clear: set wins
    err_clr = 2'b10;
    tick();
    err_clr = 2'b00;
    check("pp_set_beats_clr", err[1], 1'b1);
    // Remove stimulus: flag is sticky
    out_en    = 2'b00;
    out_data  = 2'b00;
    pad_in[1] = 1'b1;
    for (int e = 0; e < 10; e++) tick();
    check("pp_err_sticky", err, 2'b10);
    check("pp_in_restored", in_data, 2'b11);
    err_clr = 2'b10;
    tick();
    err_clr = 2'b00;
    check("pp_err_cleared", err, 2'b00);
    tick();
    check("pp_err_stays_clear", err, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
